ahb_master_bridge: RTL and testbench

Single-outstanding bridge from the CPU data port's valid/ready request interface to an AHB-Lite master port. It sits directly upstream of the AHB slaves (on-chip RAM, peripherals) through the bus decoder. It converts each byte-enabled request into one NONSEQ SINGLE transfer, waits out slave wait states, and returns read data or an error flag as a one-cycle response pulse.

---
 rtl/ahb_master_bridge.sv | 114 +++++++++++
 tb/tb_ahb_master_bridge.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_bridge.sv
// rtl/ahb_master_bridge.sv - single-outstanding valid/ready request to AHB-Lite master bridge
module ahb_master_bridge #(
    parameter logic [3:0] HPROT_VAL    = 4'b0011,
    parameter bit         ERR_ON_BADBE = 1'b1
) (
    input  logic        hclk,
    input  logic        hreset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [31:0] haddr,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic [31:0] hrdata,
    input  logic [1:0]  hresp
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        be_legal;
    logic [2:0]  be_size;
    logic [1:0]  be_lo;
    logic        unused_addr_lo;

    assign unused_addr_lo = ^req_addr[1:0];
    assign accept         = req_valid & req_ready;
    assign hburst         = 3'b000;
    assign hprot          = HPROT_VAL;

    // Only naturally aligned byte, halfword and word lane patterns map to one AHB transfer.
    always_comb begin
        be_legal = 1'b1;
        be_size  = 3'd0;
        be_lo    = 2'b00;
        case (req_be)
            4'b0001: begin be_size = 3'd0; be_lo = 2'b00; end
            4'b0010: begin be_size = 3'd0; be_lo = 2'b01; end
            4'b0100: begin be_size = 3'd0; be_lo = 2'b10; end
            4'b1000: begin be_size = 3'd0; be_lo = 2'b11; end
            4'b0011: begin be_size = 3'd1; be_lo = 2'b00; end
            4'b1100: begin be_size = 3'd1; be_lo = 2'b10; end
            4'b1111: begin be_size = 3'd2; be_lo = 2'b00; end
            default: be_legal = 1'b0;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = be_legal ? S_ADDR : S_RESP;
            S_ADDR: if (hready) state_nxt = S_DATA;
            S_DATA: if (hready) state_nxt = S_RESP;
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        rsp_valid = (state == S_RESP);
        htrans    = (state == S_ADDR) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            hwrite    <= 1'b0;
            hsize     <= 3'd0;
            haddr     <= 32'd0;
            hwdata    <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept && be_legal) begin
                hwrite <= req_write;
                hsize  <= be_size;
                haddr  <= {req_addr[31:2], be_lo};
                hwdata <= req_wdata;
            end
            if (accept && !be_legal) begin
                rsp_err <= ERR_ON_BADBE;
            end
            // hresp is only meaningful on the completing cycle; any nonzero code counts as ERROR.
            if (state == S_DATA && hready) begin
                if (!hwrite) begin
                    rsp_rdata <= hrdata;
                end
                rsp_err <= (hresp != 2'b00);
            end
        end
    end

endmodule

// File: tb/tb_ahb_master_bridge.sv
// tb/tb_ahb_master_bridge.sv - directed self-checking bench for ahb_master_bridge
module tb_ahb_master_bridge;

    logic        hclk = 1'b0;
    logic        hreset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic [1:0]  hresp;

    logic        b_req_ready;
    logic        b_rsp_valid;
    logic [31:0] b_rsp_rdata;
    logic        b_rsp_err;
    logic [1:0]  b_htrans;
    logic        b_hwrite;
    logic [2:0]  b_hsize;
    logic [2:0]  b_hburst;
    logic [3:0]  b_hprot;
    logic [31:0] b_haddr;
    logic [31:0] b_hwdata;

    int errors = 0;
    int checks = 0;

    always #5 hclk = ~hclk;

    ahb_master_bridge #(.HPROT_VAL(4'b0011), .ERR_ON_BADBE(1'b1)) dut (
        .hclk(hclk), .hreset_n(hreset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hprot(hprot), .haddr(haddr), .hwdata(hwdata),
        .hready(hready), .hrdata(hrdata), .hresp(hresp)
    );

    ahb_master_bridge #(.HPROT_VAL(4'b0011), .ERR_ON_BADBE(1'b0)) dut_b (
        .hclk(hclk), .hreset_n(hreset_n),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .htrans(b_htrans), .hwrite(b_hwrite), .hsize(b_hsize), .hburst(b_hburst),
        .hprot(b_hprot), .haddr(b_haddr), .hwdata(b_hwdata),
        .hready(hready), .hrdata(hrdata), .hresp(hresp)
    );

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: req_ready=%b expected 1", req_ready);
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h0;
        req_be    = 4'b0000;
    endtask

    task automatic test_reset();
        hreset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({htrans, hwrite, hsize, haddr, hwdata, rsp_valid, rsp_err, rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: htrans=%b hwrite=%b hsize=%0d haddr=%h hwdata=%h rsp_valid=%b rsp_err=%b rsp_rdata=%h expected all zero",
                     htrans, hwrite, hsize, haddr, hwdata, rsp_valid, rsp_err, rsp_rdata);
        end
        checks++;
        if (req_ready !== 1'b1 || hburst !== 3'b000 || hprot !== 4'b0011) begin
            errors++;
            $display("FAIL reset_static: req_ready=%b hburst=%b hprot=%b expected 1 000 0011",
                     req_ready, hburst, hprot);
        end
        hreset_n = 1'b1;
        tick();
    endtask

    task automatic test_word_write();
        hready = 1'b1;
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
        checks++;
        if (htrans !== 2'b10 || haddr !== 32'h10 || hsize !== 3'd2 || hwrite !== 1'b1) begin
            errors++;
            $display("FAIL word_addr_phase: htrans=%b haddr=%h hsize=%0d hwrite=%b expected 10 00000010 2 1",
                     htrans, haddr, hsize, hwrite);
        end
        tick();
        checks++;
        if (htrans !== 2'b00 || hwdata !== 32'hDEAD_BEEF || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL word_data_phase: htrans=%b hwdata=%h rsp_valid=%b expected 00 deadbeef 0",
                     htrans, hwdata, rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL word_resp: rsp_valid=%b rsp_err=%b req_ready=%b expected 1 0 0",
                     rsp_valid, rsp_err, req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL word_after: rsp_valid=%b req_ready=%b expected 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_byte_read();
        hready = 1'b1;
        hrdata = 32'h1122_3344;
        hresp  = 2'b00;
        issue(1'b0, 32'h0000_0020, 32'h0, 4'b0100);
        checks++;
        if (htrans !== 2'b10 || haddr !== 32'h22 || hsize !== 3'd0 || hwrite !== 1'b0) begin
            errors++;
            $display("FAIL byte_addr_phase: htrans=%b haddr=%h hsize=%0d hwrite=%b expected 10 00000022 0 0",
                     htrans, haddr, hsize, hwrite);
        end
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1122_3344 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL byte_read_resp: rsp_valid=%b rsp_rdata=%h rsp_err=%b expected 1 11223344 0",
                     rsp_valid, rsp_rdata, rsp_err);
        end
        hrdata = 32'h0;
        tick();
    endtask

    task automatic test_halfword_stall();
        int n = 0;
        int unstable = 0;
        hrdata = 32'hCAFE_F00D;
        hready = 1'b0;
        issue(1'b1, 32'h0000_0040, 32'hABCD_0000, 4'b1100);
        while (rsp_valid !== 1'b1 && n < 20) begin
            if (n <= 2 && (htrans !== 2'b10 || haddr !== 32'h42 || hsize !== 3'd1 || hwrite !== 1'b1))
                unstable++;
            if (n >= 3 && (htrans !== 2'b00 || hwdata !== 32'hABCD_0000))
                unstable++;
            hready = (n == 2 || n == 6);
            tick();
            n++;
        end
        hready = 1'b1;
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL half_stall_stable: unstable_cycles=%0d expected 0", unstable);
        end
        checks++;
        if (n != 7) begin
            errors++;
            $display("FAIL half_latency: edges_to_rsp=%0d expected 7", n);
        end
        checks++;
        if (rsp_err !== 1'b0 || rsp_rdata !== 32'h1122_3344) begin
            errors++;
            $display("FAIL half_resp: rsp_err=%b rsp_rdata=%h expected 0 11223344 (write keeps rdata)",
                     rsp_err, rsp_rdata);
        end
        hrdata = 32'h0;
        tick();
    endtask

    task automatic test_error_read();
        hready = 1'b1;
        hresp  = 2'b00;
        hrdata = 32'h5555_AAAA;
        issue(1'b0, 32'h0000_0080, 32'h0, 4'b1111);
        tick();
        hresp  = 2'b01;
        hready = 1'b0;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || htrans !== 2'b00) begin
            errors++;
            $display("FAIL err_first_cycle: rsp_valid=%b htrans=%b expected 0 00", rsp_valid, htrans);
        end
        hready = 1'b1;
        tick();
        hresp = 2'b00;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL err_resp: rsp_valid=%b rsp_err=%b expected 1 1", rsp_valid, rsp_err);
        end
        tick();
        issue(1'b0, 32'h0000_0084, 32'h0, 4'b0011);
        tick();
        hresp = 2'b10;
        tick();
        hresp = 2'b00;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL err_hresp_1x: rsp_valid=%b rsp_err=%b expected 1 1", rsp_valid, rsp_err);
        end
        tick();
    endtask

    task automatic test_bad_be();
        hready = 1'b1;
        issue(1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0101);
        checks++;
        if (htrans !== 2'b00 || b_htrans !== 2'b00) begin
            errors++;
            $display("FAIL badbe_no_xfer: htrans=%b b_htrans=%b expected 00 00", htrans, b_htrans);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL badbe_err1: rsp_valid=%b rsp_err=%b expected 1 1", rsp_valid, rsp_err);
        end
        checks++;
        if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL badbe_err0: rsp_valid=%b rsp_err=%b expected 1 0", b_rsp_valid, b_rsp_err);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL badbe_after: rsp_valid=%b req_ready=%b expected 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_in_data();
        int pulses = 0;
        hready = 1'b1;
        issue(1'b1, 32'h0000_0200, 32'h0BAD_F00D, 4'b1111);
        tick();
        hreset_n = 1'b0;
        tick();
        checks++;
        if (htrans !== 2'b00 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || hwdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_data: htrans=%b rsp_valid=%b rsp_err=%b hwdata=%h expected 00 0 0 0",
                     htrans, rsp_valid, rsp_err, hwdata);
        end
        hreset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid !== 1'b0) pulses++;
            tick();
        end
        checks++;
        if (pulses != 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release: rsp_pulses=%0d req_ready=%b expected 0 1", pulses, req_ready);
        end
    endtask

    initial begin
        hreset_n  = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_be    = 4'b0000;
        hready    = 1'b1;
        hrdata    = 32'h0;
        hresp     = 2'b00;
        test_reset();
        test_word_write();
        test_byte_read();
        test_halfword_stall();
        test_error_read();
        test_bad_be();
        test_reset_in_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
